// File: rtl/alu_vector_seq.sv
// rtl/alu_vector_seq.sv - ALU operand sequencer: corner-case table or LFSR, stepped by button or timer
module alu_vector_seq #(
  parameter int          WIDTH           = 16,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          AUTO_PERIOD     = 1024,
  parameter logic [31:0] SEED            = 32'h00000001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_btn,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic [2:0]       index,
  output logic             wrap
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_PERIOD - 1);

  logic          sync1, sync2, deb_level, btn_step;
  logic [CW-1:0] deb_cnt;
  logic [TW-1:0] tmr;
  logic [1:0]    mode_q;
  logic [31:0]   lfsr, lfsr_n;
  logic [2:0]    index_n;
  logic          tick, adv;

  function automatic logic [2*WIDTH-1:0] entry(input logic [2:0] i);
    logic [WIDTH-1:0] zero, one, ones, maxv, minv;
    zero = '0;
    one  = WIDTH'(1);
    ones = '1;
    maxv = {1'b0, {(WIDTH-1){1'b1}}};
    minv = {1'b1, {(WIDTH-1){1'b0}}};
    case (i)
      3'd0:    entry = {zero, one};
      3'd1:    entry = {one, maxv};
      3'd2:    entry = {ones, zero};
      3'd3:    entry = {zero, ones};
      3'd4:    entry = {ones, ones};
      3'd5:    entry = {maxv, one};
      3'd6:    entry = {maxv, ones};
      default: entry = {minv, one};
    endcase
  endfunction

  // Source is chosen by last cycle's mode; the generator by the current mode.
  always_comb begin
    lfsr_n  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);
    index_n = index + 3'd1;
    tick    = mode_q[0] && (tmr == TMR_LAST);
    adv     = mode_q[0] ? tick : btn_step;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      btn_step  <= 1'b0;
    end else begin
      sync1    <= step_btn;
      sync2    <= sync1;
      btn_step <= 1'b0;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LAST) begin
        deb_cnt   <= '0;
        deb_level <= sync2;
        btn_step  <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr    <= '0;
      mode_q <= 2'b00;
    end else begin
      mode_q <= mode;
      if (mode != mode_q || !mode[0] || tmr == TMR_LAST)
        tmr <= '0;
      else
        tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a     <= '0;
      b     <= WIDTH'(1);
      index <= 3'd0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      lfsr  <= SEED;
    end else begin
      valid <= adv;
      wrap  <= 1'b0;
      if (adv) begin
        if (mode[1]) begin
          lfsr <= lfsr_n;
          a    <= lfsr_n[31 -: WIDTH];
          b    <= lfsr_n[WIDTH-1:0];
        end else begin
          index  <= index_n;
          {a, b} <= entry(index_n);
          wrap   <= (index == 3'd7);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_vector_seq.sv
// tb/tb_alu_vector_seq.sv - directed-vector bench for alu_vector_seq
module tb_alu_vector_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_btn = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] a, b;
  logic        valid, wrap;
  logic [2:0]  index;

  int vectors = 0;
  int miscompares = 0;

  alu_vector_seq #(
    .WIDTH(16), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8), .SEED(32'h00000001)
  ) dut (
    .clk(clk), .reset_n(reset_n), .step_btn(step_btn), .mode(mode),
    .a(a), .b(b), .valid(valid), .index(index), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    reset_n = 1'b0;
    step_btn = 1'b0;
    mode = m;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Holds the button for 'hold' cycles and records the first valid within 'total' cycles.
  task automatic press_watch(input int hold, input int total, output int pulses, output int first,
                             output logic [15:0] ca, output logic [15:0] cb,
                             output logic [2:0] ci, output logic cw);
    pulses = 0; first = -1; ca = 'x; cb = 'x; ci = 'x; cw = 'x;
    step_btn = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (c == hold) step_btn = 1'b0;
      if (valid) begin
        pulses++;
        if (first < 0) begin
          first = c; ca = a; cb = b; ci = index; cw = wrap;
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      step_btn = ~step_btn;
      #1;
      vectors++;
      if ({a, b, index, valid, wrap} !== {16'h0000, 16'h0001, 3'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got a=%h b=%h idx=%0d v=%b w=%b want 0000 0001 0 0 0",
                 i, a, b, index, valid, wrap);
      end
    end
    step_btn = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL reset_no_stale_step got %0d pulses want 0", bad);
    end
  endtask

  task automatic test_debounce();
    int p, f;
    logic [15:0] ca, cb;
    logic [2:0] ci;
    logic cw;
    do_reset(2'b00);
    press_watch(10, 24, p, f, ca, cb, ci, cw);
    vectors++;
    if (p !== 1 || f !== 7) begin
      miscompares++;
      $display("FAIL debounce_pulse got pulses=%0d at=%0d want 1 at 7", p, f);
    end
    vectors++;
    if ({ca, cb, ci, cw} !== {16'h0001, 16'h7FFF, 3'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL debounce_value got a=%h b=%h idx=%0d w=%b want 0001 7fff 1 0", ca, cb, ci, cw);
    end
    press_watch(2, 16, p, f, ca, cb, ci, cw);
    vectors++;
    if (p !== 0) begin
      miscompares++;
      $display("FAIL glitch_rejected got pulses=%0d want 0", p);
    end
  endtask

  task automatic test_table_wrap();
    logic [15:0] ea [8];
    logic [15:0] eb [8];
    int p, f;
    logic [15:0] ca, cb;
    logic [2:0] ci;
    logic cw;
    ea = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000};
    eb = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001};
    do_reset(2'b00);
    for (int i = 0; i < 8; i++) begin
      press_watch(8, 16, p, f, ca, cb, ci, cw);
      vectors++;
      if (p !== 1 || {ca, cb, ci, cw} !== {ea[i], eb[i], 3'((i + 1) % 8), (i == 7)}) begin
        miscompares++;
        $display("FAIL table_step%0d got n=%0d a=%h b=%h idx=%0d w=%b want 1 %h %h %0d %b",
                 i, p, ca, cb, ci, cw, ea[i], eb[i], (i + 1) % 8, (i == 7));
      end
    end
  endtask

  task automatic test_auto_table();
    int gap;
    do_reset(2'b01);
    for (int n = 1; n <= 4; n++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!valid && gap < 30);
      if (n == 1) step_btn = 1'b1;
      if (n == 3) step_btn = 1'b0;
      vectors++;
      if (!valid || gap !== ((n == 1) ? 9 : 8) || index !== 3'(n)) begin
        miscompares++;
        $display("FAIL auto_tick%0d got valid=%b gap=%0d idx=%0d want 1 %0d %0d",
                 n, valid, gap, index, (n == 1) ? 9 : 8, n);
      end
    end
  endtask

  task automatic test_random_then_table();
    int p, f, bad;
    logic [15:0] ca, cb;
    logic [2:0] ci;
    logic cw;
    do_reset(2'b10);
    press_watch(8, 16, p, f, ca, cb, ci, cw);
    vectors++;
    if (p !== 1 || {ca, cb, ci, cw} !== {16'h8020, 16'h0003, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL random_first got n=%0d a=%h b=%h idx=%0d w=%b want 1 8020 0003 0 0", p, ca, cb, ci, cw);
    end
    press_watch(8, 16, p, f, ca, cb, ci, cw);
    vectors++;
    if (p !== 1 || {ca, cb, ci} !== {16'hC030, 16'h0002, 3'd0}) begin
      miscompares++;
      $display("FAIL random_second got n=%0d a=%h b=%h idx=%0d want 1 c030 0002 0", p, ca, cb, ci);
    end
    mode = 2'b00;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid || a !== 16'hC030 || b !== 16'h0002) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL mode_switch_quiet got %0d disturbed cycles want 0", bad);
    end
    press_watch(8, 16, p, f, ca, cb, ci, cw);
    vectors++;
    if (p !== 1 || {ca, cb, ci} !== {16'h0001, 16'h7FFF, 3'd1}) begin
      miscompares++;
      $display("FAIL table_after_random got n=%0d a=%h b=%h idx=%0d want 1 0001 7fff 1", p, ca, cb, ci);
    end
  endtask

  task automatic test_auto_random_reset();
    int gap;
    do_reset(2'b11);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({a, b, valid} !== {16'h0000, 16'h0001, 1'b0}) begin
      miscompares++;
      $display("FAIL midrun_reset got a=%h b=%h v=%b want 0000 0001 0", a, b, valid);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!valid && gap < 30);
    vectors++;
    if (!valid || gap !== 9 || a !== 16'h8020 || b !== 16'h0003) begin
      miscompares++;
      $display("FAIL auto_random_first got valid=%b gap=%0d a=%h b=%h want 1 9 8020 0003",
               valid, gap, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_table_wrap();
    test_auto_table();
    test_random_then_table();
    test_auto_random_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
